// File: rtl/keypad_scan_ctrl.sv
// Matrix keypad scanner: walks an active-low row strobe, samples synchronized
// columns and debounces press and release with one shared counter.
module keypad_scan_ctrl #(
  parameter int unsigned ROWS            = 4,
  parameter int unsigned COLS            = 4,
  parameter int unsigned SETTLE_CYCLES   = 16,
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            enable,
  input  logic [COLS-1:0]                 col_i,
  output logic [ROWS-1:0]                 row_o,
  output logic [$clog2(ROWS*COLS)-1:0]    key_code,
  output logic                            key_valid,
  output logic                            key_held
);

  localparam int unsigned CODE_W  = $clog2(ROWS * COLS);
  localparam int unsigned ROW_W   = $clog2(ROWS);
  localparam int unsigned COL_W   = $clog2(COLS);
  localparam int unsigned MAX_CYC = (SETTLE_CYCLES > DEBOUNCE_CYCLES) ? SETTLE_CYCLES
                                                                      : DEBOUNCE_CYCLES;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_SETTLE   = 3'd1;
  localparam logic [2:0] ST_DEBOUNCE = 3'd2;
  localparam logic [2:0] ST_REPORT   = 3'd3;
  localparam logic [2:0] ST_RELEASE  = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ROW_W-1:0]  row_idx_q, row_idx_d;
  logic [ROWS-1:0]   row_o_q, row_o_d;
  logic [CODE_W-1:0] key_code_q, key_code_d;
  logic              key_valid_q, key_valid_d;
  logic              key_held_q, key_held_d;
  logic [COL_W-1:0]  cap_col_q, cap_col_d;
  logic [COLS-1:0]   cap_pat_q, cap_pat_d;
  logic [COLS-1:0]   col_meta_q, col_s_q;

  logic [COL_W-1:0]  low_col;
  logic              col_hit;
  logic              all_high;
  logic [ROW_W-1:0]  row_nxt;
  logic [ROWS-1:0]   row_adv;

  assign row_o     = row_o_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;

  // Lowest-index active column wins when several keys share a row.
  always_comb begin
    low_col = '0;
    col_hit = 1'b0;
    for (int c = int'(COLS) - 1; c >= 0; c--) begin
      if (!col_s_q[c]) begin
        low_col = COL_W'(c);
        col_hit = 1'b1;
      end
    end
  end

  assign all_high = &col_s_q;
  assign row_nxt  = (row_idx_q == ROW_W'(ROWS - 1)) ? '0 : row_idx_q + ROW_W'(1);
  assign row_adv  = ~(ROWS'(1) << row_nxt);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    row_idx_d   = row_idx_q;
    row_o_d     = row_o_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    key_held_d  = key_held_q;
    cap_col_d   = cap_col_q;
    cap_pat_d   = cap_pat_q;

    case (state_q)
      ST_IDLE: begin
        row_o_d = '1;
        if (enable) begin
          state_d   = ST_SETTLE;
          row_idx_d = '0;
          cnt_d     = '0;
          row_o_d   = ~ROWS'(1);
        end
      end
      ST_SETTLE: begin
        if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
          cnt_d = '0;
          if (col_hit) begin
            cap_col_d = low_col;
            cap_pat_d = col_s_q;
            state_d   = ST_DEBOUNCE;
          end else begin
            row_idx_d = row_nxt;
            row_o_d   = row_adv;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DEBOUNCE: begin
        if (col_s_q == cap_pat_q) begin
          if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            state_d = ST_REPORT;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else begin
          // Pattern changed before it was stable: drop it silently and move on.
          state_d   = ST_SETTLE;
          cnt_d     = '0;
          row_idx_d = row_nxt;
          row_o_d   = row_adv;
        end
      end
      ST_REPORT: begin
        key_code_d  = CODE_W'(row_idx_q) * CODE_W'(COLS) + CODE_W'(cap_col_q);
        key_valid_d = 1'b1;
        key_held_d  = 1'b1;
        state_d     = ST_RELEASE;
        cnt_d       = '0;
      end
      ST_RELEASE: begin
        if (all_high) begin
          if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            key_held_d = 1'b0;
            state_d    = ST_SETTLE;
            cnt_d      = '0;
            row_idx_d  = row_nxt;
            row_o_d    = row_adv;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else begin
          cnt_d = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        row_o_d = '1;
      end
    endcase

    // Disabling overrides everything except the last reported code.
    if (!enable) begin
      state_d     = ST_IDLE;
      cnt_d       = '0;
      row_idx_d   = '0;
      row_o_d     = '1;
      key_valid_d = 1'b0;
      key_held_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      row_idx_q   <= '0;
      row_o_q     <= '1;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
      cap_col_q   <= '0;
      cap_pat_q   <= '1;
      col_meta_q  <= '1;
      col_s_q     <= '1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      row_idx_q   <= row_idx_d;
      row_o_q     <= row_o_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
      cap_col_q   <= cap_col_d;
      cap_pat_q   <= cap_pat_d;
      col_meta_q  <= col_i;
      col_s_q     <= col_meta_q;
    end
  end

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Directed bench for keypad_scan_ctrl with a resistive-matrix keypad model and
// a queue of expected key codes consumed on every key_valid pulse.
module tb_keypad_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       enable = 1'b0;
  logic [3:0] col_i;
  logic [3:0] row_o;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  logic [3:0][3:0] keys = '0;  // keys[row][col] = 1 when pressed
  logic [3:0]      exp_q[$];
  int              n_cmp = 0;
  int              n_err = 0;

  keypad_scan_ctrl #(
    .ROWS(4), .COLS(4), .SETTLE_CYCLES(4), .DEBOUNCE_CYCLES(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .col_i(col_i),
    .row_o(row_o), .key_code(key_code), .key_valid(key_valid), .key_held(key_held)
  );

  always #5 clk = ~clk;

  // A pressed key connects its row to its column.
  always_comb begin
    col_i = '1;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r][c] && !row_o[r]) col_i[c] = 1'b0;
  end

  // Every pulse must match the oldest outstanding expected code.
  always @(negedge clk) begin
    if (key_valid === 1'b1) begin
      n_cmp++;
      assert (exp_q.size() != 0) else begin
        n_err++;
        $error("FAIL unexpected_pulse: observed key_valid=1 code=%0d expected no pulse", key_code);
      end
      if (exp_q.size() != 0) begin
        logic [3:0] e;
        e = exp_q.pop_front();
        n_cmp++;
        assert (key_code === e) else begin
          n_err++;
          $error("FAIL pulse_code: observed %0d expected %0d", key_code, e);
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_held(input logic lvl, input int budget, input string tag);
    int n;
    n = 0;
    while (key_held !== lvl && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(key_held), 32'(lvl));
  endtask

  initial begin
    int run;
    int n;
    logic [3:0] seen;

    // Reset
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_row_o", 32'(row_o), 32'hF);
    chk("rst_key_code", 32'(key_code), 32'h0);
    chk("rst_key_valid", 32'(key_valid), 32'h0);
    chk("rst_key_held", 32'(key_held), 32'h0);
    rst_n = 1'b1;

    // 1: idle scan, 4 cycles per row, wrapping
    enable = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk($sformatf("t1_row_o_%0d", k), 32'(row_o), 32'(~(4'b0001 << ((k / 4) % 4)) & 4'hF));
    end

    // 2: r2c1 held, one pulse, release debounced
    keys[2][1] = 1'b1;
    exp_q.push_back(4'd9);
    wait_held(1'b1, 200, "t2_held_set");
    chk("t2_key_code", 32'(key_code), 32'd9);
    repeat (50) @(negedge clk);
    chk("t2_still_held", 32'(key_held), 32'h1);
    keys[2][1] = 1'b0;
    repeat (9) @(negedge clk);
    chk("t2_held_before_8", 32'(key_held), 32'h1);
    @(negedge clk);
    chk("t2_held_cleared", 32'(key_held), 32'h0);

    // 3: bouncing r1c3 never accepted, scan keeps moving
    seen = '0;
    for (int i = 0; i < 160; i++) begin
      keys[1][3] = ((i % 4) != 3);
      @(negedge clk);
      seen |= ~row_o;
    end
    keys[1][3] = 1'b0;
    chk("t3_rows_visited", 32'(seen), 32'hF);
    chk("t3_no_held", 32'(key_held), 32'h0);
    repeat (10) @(negedge clk);

    // 4: two keys on row 3, lowest column wins
    keys[3][2] = 1'b1;
    keys[3][0] = 1'b1;
    exp_q.push_back(4'd12);
    wait_held(1'b1, 200, "t4_held_set");
    chk("t4_key_code", 32'(key_code), 32'd12);
    repeat (20) @(negedge clk);
    keys[3] = '0;
    wait_held(1'b0, 40, "t4_held_cleared");

    // 5: disable during debounce of r0c0 (row 0 held longer than one settle)
    keys[0][0] = 1'b1;
    run = 0;
    n = 0;
    while (run < 6 && n < 200) begin
      @(negedge clk);
      n++;
      run = (row_o == 4'b1110) ? run + 1 : 0;
    end
    chk("t5_in_debounce", 32'(run), 32'd6);
    enable = 1'b0;
    @(negedge clk);
    chk("t5_row_o_off", 32'(row_o), 32'hF);
    chk("t5_valid_off", 32'(key_valid), 32'h0);
    chk("t5_held_off", 32'(key_held), 32'h0);
    repeat (12) @(negedge clk);
    chk("t5_row_o_idle", 32'(row_o), 32'hF);
    chk("t5_code_kept", 32'(key_code), 32'd12);
    enable = 1'b1;
    exp_q.push_back(4'd0);
    @(negedge clk);
    chk("t5_restart_row0", 32'(row_o), 32'hE);
    wait_held(1'b1, 200, "t5_held_set");
    chk("t5_key_code", 32'(key_code), 32'd0);

    // 6: asynchronous reset while a key is held
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t6_row_o", 32'(row_o), 32'hF);
    chk("t6_key_code", 32'(key_code), 32'h0);
    chk("t6_key_valid", 32'(key_valid), 32'h0);
    chk("t6_key_held", 32'(key_held), 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back(4'd0);
    wait_held(1'b1, 200, "t6_held_again");
    chk("t6_key_code_again", 32'(key_code), 32'd0);
    keys[0][0] = 1'b0;
    wait_held(1'b0, 40, "t6_held_cleared");

    repeat (10) @(negedge clk);
    chk("pending_pulses", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
